pause_frame_sync: RTL and testbench
===================================

PAUSE_FRAME_SYNC -- requirements
Module: pause_frame_sync

Interface
REQ-001 SHALL have parameter CLKSPD, default 12, meaning main clock speed in MHz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, meaning button debounce time in ms.
REQ-003 SHALL have parameter TIMEOUT_MS, default 50, meaning the maximum wait for a vblank edge before forcing a transition.
REQ-004 SHALL have port clk_sys, input, 1 bit: the single core system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port btn_raw, input, 1 bit: raw user pause button, asynchronous and bouncing, active-high.
REQ-007 SHALL have port req_in, input, 1 bit: level pause request from other logic (e.g. hiscore), active-high.
REQ-008 SHALL have port vblank, input, 1 bit: video vertical blank, active-high, synchronous to clk_sys.
REQ-009 SHALL have port user_button, output, 1 bit: debounced button level, which feeds the pause stage's user_button.
REQ-010 SHALL have port pause_request, output, 1 bit: frame-aligned pause request, which feeds the pause stage's pause_request.
REQ-011 SHALL have port sync_state, output, 2 bits: current FSM state encoding, for debug.

Function
REQ-012 SHALL pass btn_raw through a 2-flop synchronizer before any other use.
REQ-013 SHALL hold user_button as a registered stable level.
- A counter increments each cycle while the synchronized value differs from user_button.
- The counter clears whenever they are equal.
REQ-014 SHALL update user_button to the synchronized value, and clear the counter, on the cycle the counter reaches DB_CYCLES = CLKSPD*1000*DEBOUNCE_MS.
- Counter width: ceil(log2(DB_CYCLES+1)) bits; it SHALL NOT wrap.
REQ-015 SHALL define vblank_rise = vblank & ~vblank_d, where vblank_d is vblank registered one cycle.
REQ-016 SHALL implement a 4-state FSM with encodings IDLE=0, ARM=1, HOLD=2, RELEASE=3.
- sync_state SHALL be the state register.
REQ-017 SHALL decode pause_request from the registered state only: 1 in HOLD and RELEASE, 0 in IDLE and ARM.
REQ-018 IDLE: req_in=1 -> ARM.
REQ-019 ARM: vblank_rise -> HOLD. Otherwise req_in=0 -> IDLE. Otherwise timeout -> HOLD.
REQ-020 HOLD: req_in=0 -> RELEASE.
REQ-021 RELEASE: req_in=1 -> HOLD (reassert wins over vblank_rise in the same cycle). Otherwise vblank_rise or timeout -> IDLE.
REQ-022 SHALL run a timeout counter in ARM and RELEASE only.
- It clears on every state change and in IDLE and HOLD.
- Timeout fires when the counter reaches TO_CYCLES = CLKSPD*1000*TIMEOUT_MS.
REQ-023 Latency: pause_request SHALL go high on the first clock edge after the cycle in which vblank is first sampled high while in ARM (one cycle of latency).
REQ-024 SHALL let req_in asserted in the same cycle as vblank_rise while in IDLE enter ARM only, and then wait for the next vblank_rise.
REQ-025 SHALL drive the FSM from req_in only; user_button SHALL NOT affect the FSM (the pause stage toggles on it).

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set:
- state to IDLE;
- pause_request=0, user_button=0, sync_state=0;
- both counters to 0;
- the synchronizer flops and vblank_d to 0.
REQ-027 Reset in HOLD or RELEASE SHALL drop pause_request on the same edge, with no wait for vblank.
REQ-028 If req_in is still high after reset deasserts, the FSM SHALL re-enter ARM and wait for a vblank edge.

Structure
REQ-029 SHALL place the state encodings and the DB_CYCLES/TO_CYCLES derivation functions in shared package pause_pkg.
REQ-030 SHALL implement the debounce as sub-module pause_debounce (clk_sys, reset, in, out; parameter CYCLES).
- The FSM stays in the top level.

Verification (CLKSPD=1, DEBOUNCE_MS=1 -> 1000 cycles; TIMEOUT_MS=1 -> 1000 cycles)
REQ-031 Debounce: btn_raw toggles every 300 cycles for 2000 cycles, then holds at 1 -> user_button stays 0 throughout the bouncing, and rises 1002 (+/-1) cycles after the final edge.
REQ-032 Frame align: req_in=1 at cycle 10, vblank rises at cycle 400 -> sync_state=1 from cycle 11; pause_request=1 from cycle 401.
REQ-033 Release: from HOLD, req_in=0 at cycle 500, vblank rises at cycle 900 -> pause_request=1 through cycle 900 and 0 from cycle 901; sync_state returns to 0.
REQ-034 Timeout: req_in=1 with vblank held 0 -> HOLD and pause_request=1 exactly TO_CYCLES+1 cycles after entering ARM.
REQ-035 Reassert and reset: in RELEASE, req_in=1 in the same cycle as vblank_rise -> state HOLD and pause_request stays 1; then reset=1 for one cycle -> pause_request=0 the next cycle, then ARM after reset deasserts.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared definitions for the frame-aligned pause path: FSM state encodings and
// helpers that turn millisecond parameters into clock-cycle counts.
package pause_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } sync_state_t;

  function automatic int db_cycles(input int clkspd_mhz, input int debounce_ms);
    return clkspd_mhz * 1000 * debounce_ms;
  endfunction

  function automatic int to_cycles(input int clkspd_mhz, input int timeout_ms);
    return clkspd_mhz * 1000 * timeout_ms;
  endfunction

endpackage

// File: rtl/pause_debounce.sv
// Level debouncer: the output follows the input only after the input has
// disagreed with it for CYCLES consecutive clocks.
module pause_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_out;

  // The flip happens on the clock where the run length reaches CYCLES, so the
  // counter itself never has to hold CYCLES and can never wrap.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (in == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_out <= in;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign out = r_out;

endmodule

// File: rtl/pause_frame_sync.sv
// Debounces the user pause button and aligns a level pause request to video
// frame boundaries (vblank rising edge), with a timeout if vblank never comes.
module pause_frame_sync
  import pause_pkg::*;
#(
  parameter int CLKSPD      = 12,
  parameter int DEBOUNCE_MS = 10,
  parameter int TIMEOUT_MS  = 50
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       req_in,
  input  logic       vblank,
  output logic       user_button,
  output logic       pause_request,
  output logic [1:0] sync_state
);

  localparam int DB_CYCLES = db_cycles(CLKSPD, DEBOUNCE_MS);
  localparam int TO_CYCLES = to_cycles(CLKSPD, TIMEOUT_MS);
  localparam int TW = (TO_CYCLES < 1) ? 1 : $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYCLES);

  logic          r_btn_meta;
  logic          r_btn_sync;
  logic          r_vblank_d;
  logic [TW-1:0] r_to_cnt;
  sync_state_t   r_state;
  sync_state_t   w_state_next;
  logic          w_vblank_rise;
  logic          w_timeout;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_vblank_d <= 1'b0;
    end else begin
      r_btn_meta <= btn_raw;
      r_btn_sync <= r_btn_meta;
      r_vblank_d <= vblank;
    end
  end

  pause_debounce #(.CYCLES(DB_CYCLES)) u_debounce (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in      (r_btn_sync),
    .out     (user_button)
  );

  assign w_vblank_rise = vblank & ~r_vblank_d;
  assign w_timeout     = (r_to_cnt == TO_MAX);

  // ARM waits for a frame edge to start pausing, RELEASE waits for one to stop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_in) w_state_next = ST_ARM;
      end
      ST_ARM: begin
        if (w_vblank_rise)  w_state_next = ST_HOLD;
        else if (!req_in)   w_state_next = ST_IDLE;
        else if (w_timeout) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!req_in) w_state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (req_in)                         w_state_next = ST_HOLD;
        else if (w_vblank_rise || w_timeout) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Timer only runs while waiting for a frame edge; saturates at the limit.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if ((w_state_next != r_state) || (r_state == ST_IDLE) || (r_state == ST_HOLD)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign pause_request = (r_state == ST_HOLD) || (r_state == ST_RELEASE);
  assign sync_state    = r_state;

endmodule

// File: tb/tb_pause_frame_sync.sv
// Bench for pause_frame_sync: directed frame-align/debounce/timeout scenarios
// followed by randomized traffic, all checked every cycle against a model.
module tb_pause_frame_sync;

  localparam int DB = 1000;
  localparam int TO = 1000;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_raw = 1'b0;
  logic       req_in  = 1'b0;
  logic       vblank  = 1'b0;
  logic       user_button;
  logic       pause_request;
  logic [1:0] sync_state;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: paused/waiting flags, frame-edge tracking, button history
  logic m_paused, m_waiting, m_vb_prev, m_s1, m_s2, m_ub;
  int   m_wait, m_run;
  logic [0:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  pause_frame_sync #(
    .CLKSPD      (1),
    .DEBOUNCE_MS (1),
    .TIMEOUT_MS  (1)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .req_in        (req_in),
    .vblank        (vblank),
    .user_button   (user_button),
    .pause_request (pause_request),
    .sync_state    (sync_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs that edge will sample.
  task automatic model_step();
    logic rise;
    if (reset) begin
      m_paused = 0; m_waiting = 0; m_vb_prev = 0;
      m_s1 = 0; m_s2 = 0; m_ub = 0; m_wait = 0; m_run = 0;
    end else begin
      rise = vblank && !m_vb_prev;
      m_vb_prev = vblank;
      if (m_s2 != m_ub) begin
        m_run++;
        if (m_run == DB) begin
          m_ub  = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
      if (!m_paused && !m_waiting) begin
        if (req_in) begin m_waiting = 1; m_wait = 0; end
      end else if (!m_paused) begin
        if (rise)              begin m_paused = 1; m_waiting = 0; end
        else if (!req_in)      m_waiting = 0;
        else if (m_wait == TO) begin m_paused = 1; m_waiting = 0; end
        else                   m_wait++;
      end else if (!m_waiting) begin
        if (!req_in) begin m_waiting = 1; m_wait = 0; end
      end else begin
        if (req_in)                   m_waiting = 0;
        else if (rise || m_wait == TO) begin m_paused = 0; m_waiting = 0; end
        else                          m_wait++;
      end
    end
    exp_q.push_back(m_paused);
  endtask

  task automatic tick();
    logic [0:0] exp_pause;
    model_step();
    @(posedge clk_sys);
    @(negedge clk_sys);
    exp_pause = exp_q.pop_front();
    check_eq("pause_request", 32'(pause_request), 32'(exp_pause));
    check_eq("user_button", 32'(user_button), 32'(m_ub));
    check_eq("sync_state", 32'(sync_state), (m_paused ? 32'd2 : 32'd0) + (m_waiting ? 32'd1 : 32'd0));
  endtask

  initial begin
    int k;
    logic seen_high;
    int btn_left, req_left, vb_left;

    // reset state
    reset = 1; tick(); tick();
    check_eq("reset_pause", 32'(pause_request), 0);
    check_eq("reset_button", 32'(user_button), 0);
    check_eq("reset_state", 32'(sync_state), 0);
    reset = 0;

    // debounce: bouncing never reaches the stable time, then a real edge
    seen_high = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0 && i % 300 == 0) btn_raw = ~btn_raw;
      tick();
      seen_high |= user_button;
    end
    check_eq("bounce_hold", 32'(seen_high), 0);
    btn_raw = 1;
    k = 0;
    while (!user_button && k < 1100) begin tick(); k++; end
    check_eq("db_latency", k, 1002);

    // frame alignment on entry
    repeat (10) tick();
    req_in = 1; tick();
    check_eq("arm_entry", 32'(sync_state), 1);
    repeat (389) tick();
    check_eq("arm_no_pause", 32'(pause_request), 0);
    vblank = 1; tick();
    check_eq("frame_align", 32'(pause_request), 1);
    check_eq("hold_state", 32'(sync_state), 2);
    repeat (3) tick();
    vblank = 0;

    // frame alignment on release
    req_in = 0; tick();
    check_eq("release_entry", 32'(sync_state), 3);
    check_eq("release_pause", 32'(pause_request), 1);
    repeat (390) tick();
    vblank = 1; tick();
    check_eq("release_align", 32'(pause_request), 0);
    check_eq("release_idle", 32'(sync_state), 0);
    vblank = 0; tick();

    // timeout with no vblank
    req_in = 1; tick();
    check_eq("to_arm", 32'(sync_state), 1);
    k = 0;
    while (sync_state != 2 && k < 1100) begin tick(); k++; end
    check_eq("timeout_latency", k, TO + 1);

    // reassert in RELEASE beats vblank edge, then reset drops pause
    req_in = 0; tick();
    check_eq("to_release", 32'(sync_state), 3);
    repeat (5) tick();
    req_in = 1; vblank = 1; tick();
    check_eq("reassert_hold", 32'(sync_state), 2);
    check_eq("reassert_pause", 32'(pause_request), 1);
    reset = 1; tick();
    check_eq("reset_drop", 32'(pause_request), 0);
    check_eq("reset_idle", 32'(sync_state), 0);
    reset = 0; tick();
    check_eq("rearm", 32'(sync_state), 1);
    tick();
    check_eq("arm_waits", 32'(sync_state), 1);
    vblank = 0;

    // request arriving with a vblank edge in IDLE only arms
    req_in = 0; tick(); tick();
    req_in = 1; vblank = 1; tick();
    check_eq("idle_rise_arm", 32'(sync_state), 1);
    tick();
    check_eq("idle_rise_wait", 32'(sync_state), 1);
    vblank = 0; tick();
    vblank = 1; tick();
    check_eq("next_rise_hold", 32'(sync_state), 2);
    vblank = 0; req_in = 0;

    // randomized traffic
    btn_left = 0; req_left = 0; vb_left = 0;
    for (int c = 0; c < 20000; c++) begin
      if (btn_left == 0) begin
        btn_raw  = ~btn_raw;
        btn_left = ($urandom_range(0, 3) == 0) ? $urandom_range(900, 1600) : $urandom_range(1, 400);
      end else btn_left--;
      if (req_left == 0) begin
        req_in   = ~req_in;
        req_left = ($urandom_range(0, 2) == 0) ? $urandom_range(800, 1500) : $urandom_range(1, 300);
      end else req_left--;
      if (vb_left == 0) begin
        if (vblank) begin
          vblank  = 0;
          vb_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1600) : $urandom_range(20, 400);
        end else begin
          vblank  = 1;
          vb_left = $urandom_range(1, 5);
        end
      end else vb_left--;
      reset = ($urandom_range(0, 1999) == 0);
      tick();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
